// File: rtl/mac_window_if.sv
// Tap-input and result-output handshake bundle for mac_window.
// The slave modport is the MAC engine; the master modport is the producer/consumer side.
interface mac_window_if #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 8
);
  logic                     mode;
  logic                     in_valid;
  logic                     in_ready;
  logic        [PIX_W-1:0]  value_a;
  logic signed [COEF_W-1:0] value_b;
  logic                     out_valid;
  logic                     out_ready;
  logic        [OUT_W-1:0]  result;
  logic                     overflow;

  modport master (
    output mode, in_valid, value_a, value_b, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  mode, in_valid, value_a, value_b, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/mac_window.sv
// Windowed multiply-accumulate: TAPS (pixel x coefficient) products per window at full
// precision, then clamp or abs-clamp to OUT_W bits behind a one-entry valid/ready stage.
module mac_window #(
  parameter  int PIX_W  = 8,
  parameter  int COEF_W = 8,
  parameter  int TAPS   = 9,
  parameter  int OUT_W  = 8,
  localparam int ACC_W  = PIX_W + COEF_W + $clog2(TAPS) + 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  mac_window_if.slave bus
);

  localparam int                      CNT_W   = $clog2(TAPS);
  localparam logic [CNT_W-1:0]        LAST    = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] MAX_OUT = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  // Returns {overflow, value}; abs_mode folds negative sums before the upper clamp.
  function automatic logic [OUT_W:0] sat_out(input logic signed [ACC_W-1:0] s,
                                             input logic                    abs_mode);
    logic signed [ACC_W-1:0] v;
    v = (abs_mode && s[ACC_W-1]) ? -s : s;
    if (v[ACC_W-1])   return {1'b1, {OUT_W{1'b0}}};
    if (v > MAX_OUT)  return {1'b1, {OUT_W{1'b1}}};
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic [CNT_W-1:0]        r_cnt_p0;
  logic signed [ACC_W-1:0] r_acc_p0;
  logic                    r_mode_p0;
  logic                    r_vld_p1;
  logic [OUT_W-1:0]        r_result_p1;
  logic                    r_ovf_p1;

  logic signed [ACC_W-1:0] w_a_ext;
  logic signed [ACC_W-1:0] w_b_ext;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_sum;
  logic [OUT_W:0]          w_sat;
  logic                    w_last;
  logic                    w_in_ready;
  logic                    w_accept;

  assign w_a_ext = {{(ACC_W-PIX_W){1'b0}}, bus.value_a};
  assign w_b_ext = {{(ACC_W-COEF_W){bus.value_b[COEF_W-1]}}, bus.value_b};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_sum   = r_acc_p0 + w_prod;
  assign w_sat   = sat_out(w_sum, r_mode_p0);

  // Only the closing tap has to wait for the output slot to free up.
  assign w_last     = (r_cnt_p0 == LAST);
  assign w_in_ready = !reset && !clear && !(w_last && r_vld_p1 && !bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_p1;
  assign bus.result    = r_result_p1;
  assign bus.overflow  = r_ovf_p1;

  // Stage p0: tap counter and accumulator
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt_p0  <= '0;
      r_acc_p0  <= '0;
      r_mode_p0 <= 1'b0;
    end else if (clear) begin
      r_cnt_p0 <= '0;
      r_acc_p0 <= '0;
    end else if (w_accept) begin
      if (r_cnt_p0 == '0) begin
        r_acc_p0  <= w_prod;
        r_mode_p0 <= bus.mode;
        r_cnt_p0  <= CNT_W'(1);
      end else if (w_last) begin
        r_cnt_p0 <= '0;
      end else begin
        r_acc_p0 <= w_sum;
        r_cnt_p0 <= r_cnt_p0 + CNT_W'(1);
      end
    end
  end

  // Stage p1: one-entry result holding register; a new result outranks the handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_p1    <= 1'b0;
      r_result_p1 <= '0;
      r_ovf_p1    <= 1'b0;
    end else if (w_accept && w_last) begin
      r_vld_p1    <= 1'b1;
      r_result_p1 <= w_sat[OUT_W-1:0];
      r_ovf_p1    <= w_sat[OUT_W];
    end else if (r_vld_p1 && bus.out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_window.sv
// Scoreboard bench for mac_window: the driver pushes expected results computed from
// plain integer window sums; a monitor pops and compares on every output handshake.
module tb_mac_window;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 9;
  localparam int OUT_W  = 8;
  localparam int MAXO   = (1 << OUT_W) - 1;

  logic clock = 1'b0;
  logic reset;
  logic clear;

  mac_window_if #(.PIX_W(PIX_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) bus ();

  mac_window #(.PIX_W(PIX_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  int win[$];
  bit wmode;
  int exp_q[$];
  bit rnd_on = 1'b0;
  int pix[TAPS];
  int coef[TAPS];

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Reference: a window is the list of its products; mode is whatever came with the first tap.
  function automatic void model_accept(int a, int b, bit m);
    int s;
    int v;
    int o;
    if (win.size() == 0) wmode = m;
    win.push_back(a * b);
    if (win.size() == TAPS) begin
      s = 0;
      foreach (win[i]) s += win[i];
      if (wmode) s = (s < 0) ? -s : s;
      if (s < 0)         begin v = 0;    o = 1; end
      else if (s > MAXO) begin v = MAXO; o = 1; end
      else               begin v = s;    o = 0; end
      exp_q.push_back(o * 256 + v);
      win.delete();
    end
  endfunction

  initial begin
    int e;
    forever begin
      @(negedge clock);
      #2;
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("result", int'(bus.result), e & 255);
          chk("overflow", int'(bus.overflow), e >> 8);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (rnd_on) bus.out_ready = 1'($urandom_range(1));
    end
  end

  task automatic drive_tap(input int a, input int b, input bit m);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clock);
      clear        = 1'b0;
      bus.in_valid = 1'b1;
      bus.value_a  = PIX_W'(a);
      bus.value_b  = COEF_W'(b);
      bus.mode     = m;
      #1;
      if (bus.in_ready) begin
        model_accept(a, b, m);
        done = 1'b1;
      end else if (++n > 200) begin
        chk("in_ready_timeout", 0, 1);
        done = 1'b1;
      end
      @(posedge clock);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      clear        = 1'b0;
      bus.in_valid = 1'b0;
    end
  endtask

  // Sobel Gx layout; mirror negates the kernel. Columns: left, middle, right.
  task automatic set_sobel(input int l, input int mid, input int r, input bit mirror);
    int gx[TAPS] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    for (int i = 0; i < TAPS; i++) begin
      coef[i] = mirror ? -gx[i] : gx[i];
      pix[i]  = (i % 3 == 0) ? l : ((i % 3 == 1) ? mid : r);
    end
  endtask

  task automatic send_window(input bit m, input int toggle_at);
    for (int i = 0; i < TAPS; i++)
      drive_tap(pix[i], coef[i], (toggle_at >= 0 && i >= toggle_at) ? !m : m);
  endtask

  task automatic set_ones(input int c);
    for (int i = 0; i < TAPS; i++) begin
      pix[i]  = 1;
      coef[i] = c;
    end
  endtask

  initial begin
    reset         = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.value_a   = '0;
    bus.value_b   = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clock);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(bus.in_ready), 1);

    // Flat field through Gx: zero, and out_valid rises right after the 9th accept
    set_sobel(10, 10, 10, 1'b0);
    for (int i = 0; i < TAPS - 1; i++) drive_tap(pix[i], coef[i], 1'b0);
    #1;
    chk("latency_before", int'(bus.out_valid), 0);
    drive_tap(pix[TAPS-1], coef[TAPS-1], 1'b0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    #1;
    chk("latency_after", int'(bus.out_valid), 1);
    idle(2);

    set_sobel(0, 50, 100, 1'b0);
    send_window(1'b0, -1);
    set_sobel(0, 50, 100, 1'b1);
    send_window(1'b0, -1);
    send_window(1'b1, -1);
    set_sobel(0, 33, 20, 1'b1);
    send_window(1'b1, -1);
    send_window(1'b0, -1);
    send_window(1'b1, 5);
    send_window(1'b0, 5);
    idle(3);

    // Backpressure: final tap of window 2 stalls behind a held result
    bus.out_ready = 1'b0;
    set_ones(1);
    send_window(1'b0, -1);
    for (int i = 0; i < TAPS - 1; i++) drive_tap(1, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      bus.in_valid = 1'b1;
      #1;
      chk("stall_in_ready", int'(bus.in_ready), 0);
      chk("stall_out_valid", int'(bus.out_valid), 1);
      chk("stall_result", int'(bus.result), 9);
    end
    @(negedge clock);
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", int'(bus.in_ready), 1);
    if (bus.in_ready) model_accept(1, 1, 1'b0);
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    chk("replace_out_valid", int'(bus.out_valid), 1);
    chk("replace_result", int'(bus.result), 9);
    bus.out_ready = 1'b1;
    idle(2);

    // clear drops a partial window but leaves a held result alone
    bus.out_ready = 1'b0;
    send_window(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_tap(1, 5, 1'b0);
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.value_a  = PIX_W'(1);
    bus.value_b  = COEF_W'(5);
    clear        = 1'b1;
    #1;
    chk("clear_in_ready", int'(bus.in_ready), 0);
    win.delete();
    @(negedge clock);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("clear_out_valid", int'(bus.out_valid), 1);
    chk("clear_result", int'(bus.result), 9);
    chk("clear_overflow", int'(bus.overflow), 0);
    bus.out_ready = 1'b1;
    send_window(1'b0, -1);
    idle(3);

    // Reset mid-window with a saturated result held
    bus.out_ready = 1'b0;
    set_sobel(0, 50, 100, 1'b0);
    send_window(1'b0, -1);
    for (int i = 0; i < 3; i++) drive_tap(pix[i], coef[i], 1'b0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    #1;
    chk("held_ovf_before_reset", int'(bus.overflow), 1);
    reset = 1'b1;
    #1;
    chk("reset_in_ready", int'(bus.in_ready), 0);
    win.delete();
    exp_q.delete();
    @(negedge clock);
    #1;
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_result", int'(bus.result), 0);
    chk("reset_overflow", int'(bus.overflow), 0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    set_sobel(0, 7, 20, 1'b1);
    send_window(1'b1, -1);
    idle(3);

    // Random windows with gaps, clears and output backpressure
    rnd_on = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(29) == 0) begin
        @(negedge clock);
        bus.in_valid = 1'b1;
        clear        = 1'b1;
        #1;
        chk("rnd_clear_in_ready", int'(bus.in_ready), 0);
        win.delete();
        @(posedge clock);
      end else if ($urandom_range(4) == 0) begin
        idle(1);
      end else begin
        drive_tap(int'($urandom_range(MAXO)),
                  int'($urandom_range(255)) - 128,
                  1'($urandom_range(1)));
      end
    end
    rnd_on = 1'b0;
    @(negedge clock);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    clear         = 1'b0;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clock);
    chk("drain_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_window.md
# mac_window

Parametrised multi-tap multiply-accumulate engine for the border-detection datapath. It consumes one (pixel, coefficient) pair per accepted cycle and accumulates a full TAPS-long window at full precision. At window end it emits one OUT_W-bit result, either clamped or absolute-then-clamped. Results leave through a valid/ready output stage, and the engine accumulates the next window while a result is held. It replaces the single-window 8-bit MAC in the convolution path (e.g. Sobel Gx/Gy 3x3).

## Interface
- PIX_W, 8, pixel width (unsigned)
- COEF_W, 8, coefficient width (two's complement)
- TAPS, 9, products per window (>= 2)
- OUT_W, 8, result width (unsigned)
- ACC_W, PIX_W+COEF_W+$clog2(TAPS)+1, accumulator width (derived; do not override)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; full reinitialisation
- clear  in  1  synchronous, active-high; discard partial window only
- mode  in  1  0 = clamp, 1 = absolute value then clamp; sampled with first tap of each window
- in_valid  in  1  tap pair present
- in_ready  out  1  tap pair accepted when in_valid && in_ready
- value_a  in  PIX_W  unsigned pixel
- value_b  in  COEF_W  signed coefficient
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts when out_valid && out_ready
- result  out  OUT_W  window result
- overflow  out  1  clamp was applied to this result; valid with out_valid

## Operation
- Product: signed ({1'b0,value_a} * value_b), sign-extended to ACC_W. No intermediate truncation.
- Tap counter 0..TAPS-1. Accept at count 0 loads acc = product and latches mode. Accept at count 1..TAPS-2 does acc += product. Accept at count TAPS-1 finalises the window. The counter wraps to 0 after the last tap.
- Final sum S = acc + last product (ACC_W, signed). Mode 0: S < 0 → 0; S > 2^OUT_W-1 → 2^OUT_W-1; else S. Mode 1: apply the same upper clamp to |S|. overflow = 1 iff a clamp changed the value. In mode 0, overflow = 1 for any S < 0.
- Output stage: one entry. The final accept loads result and overflow and sets out_valid. An out_valid && out_ready handshake clears out_valid unless a new result loads on the same edge; that load has priority.
- States: IDLE (count 0, acc invalid) and ACCUM (count > 0). OUTPUT (out_valid) is independent of them, so window N+1 accumulates while result N waits.
- in_ready = !reset && !clear && !(count == TAPS-1 && out_valid && !out_ready). Only the final tap stalls on backpressure.
- clear: count → 0 and the partial acc is discarded. out_valid, result and overflow are untouched. A tap presented in the same cycle is not accepted (in_ready = 0).
- reset: count 0, acc 0, out_valid 0, result 0, overflow 0. Reset mid-window or while a result is held drops everything. reset has priority over clear.
- mode changes mid-window are ignored until the next window's first tap.

## Timing
- Reset values: out_valid 0, result 0, overflow 0. in_ready is 0 while reset is high and 1 on the first cycle after.
- Latency: out_valid rises on the cycle after the edge accepting tap TAPS-1. result and overflow are registered and stable while out_valid && !out_ready.
- Throughput: with out_ready held at 1 and in_valid continuous, one result every TAPS cycles, with no bubbles.
- If the final tap is accepted on the same edge as an output handshake, the new result replaces the old one and out_valid stays 1.
- in_valid may drop between taps; count and acc hold.

## Test plan
- Defaults, mode 0, coefficients Sobel Gx (-1,0,1,-2,0,2,-1,0,1), all pixels 10 → result 0, overflow 0, out_valid exactly one cycle after the 9th accept.
- Same kernel, left column 0, right column 100 (S = 400): mode 0 → 255, overflow 1. Mirrored (S = -400): mode 0 → 0, overflow 1; mode 1 → 255, overflow 1.
- Mirrored with pixel 20 (S = -80): mode 1 → 80, overflow 0; mode 0 → 0, overflow 1. mode toggled at tap 5 has no effect.
- Backpressure: out_ready = 0, stream two all-ones windows (coefficient 1, result 9). The first 8 taps of window 2 are accepted, then in_ready = 0 at the 9th. Result 9 stays stable. One cycle of out_ready releases the stall and the second 9 appears.
- clear after 4 taps of coefficient 5, then a full window of pixel 1 and coefficient 1 → result 9, not 29. A tap with clear asserted in the same cycle is not accepted. A held result is unaffected by clear.
- reset asserted mid-window and with out_valid = 1 → out_valid, result and overflow become 0 next cycle. The following window produces a correct result.
